// File: rtl/bythoven_pkg.sv
// Shared constants and types for the song-loader datapath.
// The loader state encoding lives here so every consumer of the loader sees the same names.
package bythoven_pkg;

    localparam int ADDR_W         = 18;
    localparam int DATA_W         = 16;
    localparam int CYCLES_PER_SEC = 50_000_000;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        SETUP,
        STROBE,
        HOLD,
        FINISH
    } loader_state_t;

    // Increments by one, but sticks at the top value instead of rolling over.
    function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] value);
        return (value == ADDR_MAX) ? value : value + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/sram_write_timer.sv
// Down-counter that measures how long the SRAM write strobe stays low.
// Load it one cycle before the strobe; expire is high during the last strobe cycle.
module sram_write_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire = (count == WIDTH'(1)) && !load;

endmodule

// File: rtl/sram_loader.sv
// Streams song instruction words from a valid/ready producer into an asynchronous SRAM.
// Each word goes through SETUP, a WE_LOW_CYCLES-long write strobe and one data-hold cycle.
module sram_loader
    import bythoven_pkg::*;
#(
    parameter int WE_LOW_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d_out,
    output logic              sram_d_oe,
    output logic              sram_we,
    output logic              sram_ce,
    output logic              sram_oe,
    output logic              sram_lb,
    output logic              sram_ub,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_count,
    output logic              wrapped
);

    // Legal strobe widths are 1..15, so four bits always suffice.
    localparam logic [3:0] WE_LOW = 4'(WE_LOW_CYCLES);

    loader_state_t state;
    logic          last_word;
    logic          timer_load;
    logic          timer_expire;

    assign timer_load = (state == SETUP);
    assign sram_oe    = 1'b1;

    sram_write_timer #(
        .WIDTH(4)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_value(WE_LOW),
        .expire    (timer_expire)
    );

    // Every output is a flop updated on the transition into the state that needs it,
    // so the SRAM pins never see decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sram_a     <= '0;
            sram_d_out <= '0;
            last_word  <= 1'b0;
            word_count <= '0;
            wrapped    <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sram_we    <= 1'b1;
            sram_d_oe  <= 1'b0;
            sram_ce    <= 1'b1;
            sram_lb    <= 1'b1;
            sram_ub    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= WAIT_DATA;
                        sram_a     <= start_addr;
                        word_count <= '0;
                        wrapped    <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        sram_ce    <= 1'b0;
                        sram_lb    <= 1'b0;
                        sram_ub    <= 1'b0;
                    end
                end

                WAIT_DATA: begin
                    if (in_valid) begin
                        state      <= SETUP;
                        sram_d_out <= in_data;
                        last_word  <= in_last;
                        in_ready   <= 1'b0;
                        sram_d_oe  <= 1'b1;
                    end
                end

                SETUP: begin
                    state   <= STROBE;
                    sram_we <= 1'b0;
                end

                STROBE: begin
                    if (timer_expire) begin
                        state   <= HOLD;
                        sram_we <= 1'b1;
                    end
                end

                HOLD: begin
                    word_count <= sat_inc(word_count);
                    sram_d_oe  <= 1'b0;
                    if (last_word) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        // The address space is circular; running off the top is flagged, not fatal.
                        state    <= WAIT_DATA;
                        in_ready <= 1'b1;
                        sram_a   <= sram_a + ADDR_W'(1);
                        if (sram_a == ADDR_MAX) begin
                            wrapped <= 1'b1;
                        end
                    end
                end

                FINISH: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    sram_ce <= 1'b1;
                    sram_lb <= 1'b1;
                    sram_ub <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_loader.sv
// Directed bench for sram_loader: one task per scenario, each with its own inline expectations.
// A passive monitor logs every write strobe (address, data, low-cycle count) for the tasks to inspect.
module tb_sram_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [17:0] start_addr = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;

    logic        in_ready;
    logic [17:0] sram_a;
    logic [15:0] sram_d_out;
    logic        sram_d_oe;
    logic        sram_we;
    logic        sram_ce;
    logic        sram_oe;
    logic        sram_lb;
    logic        sram_ub;
    logic        busy;
    logic        done;
    logic [17:0] word_count;
    logic        wrapped;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    sram_loader #(
        .WE_LOW_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_addr(start_addr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sram_a    (sram_a),
        .sram_d_out(sram_d_out),
        .sram_d_oe (sram_d_oe),
        .sram_we   (sram_we),
        .sram_ce   (sram_ce),
        .sram_oe   (sram_oe),
        .sram_lb   (sram_lb),
        .sram_ub   (sram_ub),
        .busy      (busy),
        .done      (done),
        .word_count(word_count),
        .wrapped   (wrapped)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    logic [17:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_low_q[$];
    int          low_run = 0;
    int          unstable = 0;
    logic [17:0] cap_a;
    logic [15:0] cap_d;

    // Write-strobe monitor: captures A/D on the first low cycle, flags any change while WE stays low.
    always @(negedge clk) begin
        if (rst) begin
            low_run = 0;
        end else if (sram_we === 1'b0) begin
            if (low_run == 0) begin
                cap_a = sram_a;
                cap_d = sram_d_out;
                wr_addr_q.push_back(sram_a);
                wr_data_q.push_back(sram_d_out);
            end else if (sram_a !== cap_a || sram_d_out !== cap_d || sram_d_oe !== 1'b1) begin
                unstable++;
            end
            low_run++;
        end else if (low_run != 0) begin
            wr_low_q.push_back(low_run);
            low_run = 0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_low_q.delete();
        unstable = 0;
    endtask

    task automatic start_session(input logic [17:0] addr);
        start_addr = addr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one word and returns once the accepting edge has passed (now in SETUP).
    task automatic send_word(input logic [15:0] d, input logic l, output int acc);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL send_word_ready: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
        end
        acc = cyc;
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output int pulses, output int at);
        pulses = 0;
        at = -1;
        repeat (budget) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                at = cyc;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({sram_we, sram_ce, sram_oe, sram_lb, sram_ub, sram_d_oe, in_ready, busy, done, wrapped} !== 10'b11111_00000) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %b expected %b",
                     {sram_we, sram_ce, sram_oe, sram_lb, sram_ub, sram_d_oe, in_ready, busy, done, wrapped}, 10'b11111_00000);
        end
        checks++;
        if ({sram_a, sram_d_out, word_count} !== 52'h0) begin
            errors++;
            $display("[TB] FAIL reset_values: got a=%h d=%h wc=%h expected all zero", sram_a, sram_d_out, word_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        int acc, pulses, at;
        logic [17:0] a0;
        logic [15:0] d0;
        int l0;
        clear_log();
        start_session(18'h00010);
        checks++;
        if ({busy, in_ready, sram_ce, sram_lb, sram_ub, sram_oe} !== 6'b110001) begin
            errors++;
            $display("[TB] FAIL single_wait_state: got %b expected %b", {busy, in_ready, sram_ce, sram_lb, sram_ub, sram_oe}, 6'b110001);
        end
        send_word(16'hA5C3, 1'b1, acc);
        in_valid = 1'b0;
        checks++;
        if ({sram_d_oe, sram_we, in_ready, sram_a, sram_d_out} !== {3'b110, 18'h00010, 16'hA5C3}) begin
            errors++;
            $display("[TB] FAIL single_setup: got oe=%b we=%b rdy=%b a=%h d=%h expected 1 1 0 00010 a5c3",
                     sram_d_oe, sram_we, in_ready, sram_a, sram_d_out);
        end
        wait_done(12, pulses, at);
        a0 = (wr_addr_q.size() > 0) ? wr_addr_q[0] : 'x;
        d0 = (wr_data_q.size() > 0) ? wr_data_q[0] : 'x;
        l0 = (wr_low_q.size() > 0) ? wr_low_q[0] : -1;
        checks++;
        if (wr_addr_q.size() != 1 || a0 !== 18'h00010 || d0 !== 16'hA5C3) begin
            errors++;
            $display("[TB] FAIL single_write: got n=%0d a=%h d=%h expected n=1 a=00010 d=a5c3", wr_addr_q.size(), a0, d0);
        end
        checks++;
        if (l0 != 2 || unstable != 0) begin
            errors++;
            $display("[TB] FAIL single_we_low: got low=%0d unstable=%0d expected low=2 unstable=0", l0, unstable);
        end
        checks++;
        if (pulses != 1 || at - acc != 5) begin
            errors++;
            $display("[TB] FAIL single_done: got pulses=%0d latency=%0d expected 1 and 5", pulses, at - acc);
        end
        checks++;
        if (word_count !== 18'd1 || busy !== 1'b0 || wrapped !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_final: got wc=%0d busy=%b wrapped=%b expected 1 0 0", word_count, busy, wrapped);
        end
    endtask

    task automatic test_back_to_back();
        int acc[4];
        int pulses, at;
        clear_log();
        start_session(18'h00000);
        for (int i = 0; i < 4; i++) begin
            send_word(16'(i + 1), (i == 3), acc[i]);
        end
        in_valid = 1'b0;
        wait_done(15, pulses, at);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc[i + 1] - acc[i] != 5) begin
                errors++;
                $display("[TB] FAIL b2b_ready_period%0d: got %0d cycles expected 5", i, acc[i + 1] - acc[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== 18'(i) || wr_data_q[i] !== 16'(i + 1) || wr_low_q[i] != 2) begin
                errors++;
                $display("[TB] FAIL b2b_write%0d: got n=%0d expected a=%0d d=%0d low=2", i, wr_addr_q.size(), i, i + 1);
            end
        end
        checks++;
        if (word_count !== 18'd4 || pulses != 1 || unstable != 0) begin
            errors++;
            $display("[TB] FAIL b2b_final: got wc=%0d done_pulses=%0d unstable=%0d expected 4 1 0", word_count, pulses, unstable);
        end
    endtask

    task automatic test_stall();
        int acc, pulses, at, waited, viol;
        clear_log();
        start_session(18'h00020);
        send_word(16'h1111, 1'b0, acc);
        in_valid = 1'b0;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready !== 1'b1 || sram_we !== 1'b1 || sram_d_oe !== 1'b0 || busy !== 1'b1) viol++;
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("[TB] FAIL stall_wait_data: got %0d bad cycles expected 0", viol);
        end
        send_word(16'h2222, 1'b1, acc);
        in_valid = 1'b0;
        wait_done(12, pulses, at);
        checks++;
        if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 18'h00020 || wr_addr_q[1] !== 18'h00021
            || wr_data_q[0] !== 16'h1111 || wr_data_q[1] !== 16'h2222) begin
            errors++;
            $display("[TB] FAIL stall_writes: got n=%0d expected 2 writes 00020/1111 00021/2222", wr_addr_q.size());
        end
        checks++;
        if (word_count !== 18'd2 || pulses != 1) begin
            errors++;
            $display("[TB] FAIL stall_final: got wc=%0d pulses=%0d expected 2 1", word_count, pulses);
        end
    endtask

    task automatic test_wrap();
        int acc, pulses, at;
        clear_log();
        start_session(18'h3FFFF);
        send_word(16'hBEEF, 1'b0, acc);
        send_word(16'hCAFE, 1'b1, acc);
        in_valid = 1'b0;
        wait_done(12, pulses, at);
        checks++;
        if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 18'h3FFFF || wr_addr_q[1] !== 18'h00000
            || wr_data_q[0] !== 16'hBEEF || wr_data_q[1] !== 16'hCAFE) begin
            errors++;
            $display("[TB] FAIL wrap_writes: got n=%0d expected 3ffff/beef then 00000/cafe", wr_addr_q.size());
        end
        checks++;
        if (wrapped !== 1'b1 || word_count !== 18'd2) begin
            errors++;
            $display("[TB] FAIL wrap_flag: got wrapped=%b wc=%0d expected 1 2", wrapped, word_count);
        end
    endtask

    task automatic test_start_while_busy();
        int acc, waited;
        clear_log();
        start_session(18'h00080);
        checks++;
        if (wrapped !== 1'b0 || word_count !== 18'd0) begin
            errors++;
            $display("[TB] FAIL busy_start_clear: got wrapped=%b wc=%0d expected 0 0", wrapped, word_count);
        end
        start_addr = 18'h00100;
        start = 1'b1;
        send_word(16'h000A, 1'b0, acc);
        send_word(16'h000B, 1'b0, acc);
        send_word(16'h000C, 1'b1, acc);
        in_valid = 1'b0;
        waited = 0;
        while (done !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_done_seen: done=%b after %0d cycles expected 1", done, waited);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_finish_start: got busy=%b in_ready=%b expected 0 0", busy, in_ready);
        end
        checks++;
        if (wr_addr_q.size() != 3 || wr_addr_q[0] !== 18'h00080 || wr_addr_q[1] !== 18'h00081
            || wr_addr_q[2] !== 18'h00082 || word_count !== 18'd3) begin
            errors++;
            $display("[TB] FAIL busy_sequence: got n=%0d wc=%0d expected 3 writes at 80..82 and wc=3", wr_addr_q.size(), word_count);
        end
    endtask

    task automatic test_reset_mid_strobe();
        int acc, pulses, at;
        clear_log();
        start_session(18'h00040);
        send_word(16'h1234, 1'b1, acc);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (sram_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_strobe_pre: got we=%b expected 0", sram_we);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sram_we, sram_ce, sram_oe, sram_lb, sram_ub, sram_d_oe, in_ready, busy, done, wrapped} !== 10'b11111_00000) begin
            errors++;
            $display("[TB] FAIL rst_strobe_async: got %b expected %b",
                     {sram_we, sram_ce, sram_oe, sram_lb, sram_ub, sram_d_oe, in_ready, busy, done, wrapped}, 10'b11111_00000);
        end
        checks++;
        if ({sram_a, sram_d_out, word_count} !== 52'h0) begin
            errors++;
            $display("[TB] FAIL rst_strobe_values: got a=%h d=%h wc=%h expected all zero", sram_a, sram_d_out, word_count);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        start_session(18'h00005);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || sram_a !== 18'h00005) begin
            errors++;
            $display("[TB] FAIL rst_first_start: got busy=%b rdy=%b a=%h expected 1 1 00005", busy, in_ready, sram_a);
        end
        send_word(16'h00AA, 1'b1, acc);
        in_valid = 1'b0;
        wait_done(12, pulses, at);
        checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 18'h00005 || wr_data_q[0] !== 16'h00AA
            || word_count !== 18'd1 || pulses != 1) begin
            errors++;
            $display("[TB] FAIL rst_new_session: got n=%0d wc=%0d pulses=%0d expected 1 write 00005/00aa wc=1 pulses=1",
                     wr_addr_q.size(), word_count, pulses);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_start_while_busy();
        test_reset_mid_strobe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_loader.md
SRAM_LOADER -- requirements
Module: sram_loader

Interface
REQ-001 WE_LOW_CYCLES, 2, number of CLK cycles SRAM_WE is held low per write (legal range 1..15).
REQ-002 CLK  input  1  system clock, 50 MHz, all state changes on rising edge.
REQ-003 RST  input  1  reset; one clock, asynchronous and active-high.
REQ-004 START  input  1  one-cycle pulse that begins a load session; sampled only in IDLE.
REQ-005 START_ADDR  input  18  SRAM word address of the first write, latched on accepted START.
REQ-006 IN_VALID  input  1  producer has a word on IN_DATA.
REQ-007 IN_DATA  input  16  song instruction word to store.
REQ-008 IN_LAST  input  1  qualifies IN_DATA as the final word of the session.
REQ-009 IN_READY  output  1  loader accepts IN_DATA this cycle.
REQ-010 SRAM_A  output  18  write address.
REQ-011 SRAM_D_OUT  output  16  write data; the top level resolves the tristate.
REQ-012 SRAM_D_OE  output  1  loader drives the SRAM data bus.
REQ-013 SRAM_WE / SRAM_CE / SRAM_OE / SRAM_LB / SRAM_UB  output  1 each  active-low SRAM strobes.
REQ-014 BUSY  output  1  session in progress; the top level gives the SRAM bus to the loader while high.
REQ-015 DONE  output  1  one-cycle pulse at session end.
REQ-016 WORD_COUNT  output  18  words written in the current or last session.
REQ-017 WRAPPED  output  1  sticky flag: the address wrapped during the session.

Function
REQ-018 FSM states: IDLE, WAIT_DATA, SETUP, STROBE, HOLD, FINISH.
REQ-019 IDLE: START=1 -> WAIT_DATA.
  - Latch START_ADDR into the address register.
  - Clear WORD_COUNT and WRAPPED.
REQ-020 IN_READY is 1 only in WAIT_DATA.
  - A word is accepted when IN_VALID & IN_READY; its data and IN_LAST are latched; next state is SETUP.
  - WAIT_DATA with no accepted word holds indefinitely, with no timeout.
REQ-021 SETUP lasts 1 cycle.
  - SRAM_A and SRAM_D_OUT are stable; SRAM_D_OE=1, SRAM_WE=1.
REQ-022 STROBE lasts exactly WE_LOW_CYCLES cycles with SRAM_WE=0; SRAM_A and SRAM_D_OUT stay stable.
REQ-023 HOLD lasts 1 cycle with SRAM_WE=1 and SRAM_D_OE=1, for data hold.
  - WORD_COUNT increments at the end of HOLD.
  - Latched last=1 -> FINISH.
  - Latched last=0 -> address+1 -> WAIT_DATA.
REQ-024 Address 18'h3FFFF + 1 wraps to 0 and sets WRAPPED; writing continues.
REQ-025 WORD_COUNT saturates at 18'h3FFFF.
REQ-026 FINISH lasts 1 cycle with DONE=1, then -> IDLE.
REQ-027 Throughput: WE_LOW_CYCLES+2 cycles per write when IN_VALID is held high, plus 1 WAIT_DATA cycle.
  - WE_LOW_CYCLES=2 gives 5 cycles/word.
REQ-028 BUSY=1 in every state except IDLE.
REQ-029 SRAM strobe levels:
  - SRAM_CE=0 while BUSY, else 1.
  - SRAM_OE=1 always; the loader never reads.
  - SRAM_LB=SRAM_UB=0 while BUSY, else 1.
REQ-030 SRAM_D_OE=1 only in SETUP, STROBE and HOLD.
REQ-031 START while BUSY is ignored, including START coinciding with FINISH.
REQ-032 IN_VALID outside WAIT_DATA has no effect; the producer holds the word until IN_READY.

Reset
REQ-033 RST asserted forces the following asynchronously, including mid-STROBE:
  - state=IDLE, SRAM_WE=1, SRAM_D_OE=0, SRAM_CE=1.
  - IN_READY=0, BUSY=0, DONE=0.
  - SRAM_A=0, SRAM_D_OUT=0, WORD_COUNT=0, WRAPPED=0.
REQ-034 After RST deasserts, the first START is honoured on the first rising edge.

Structure
REQ-035 Shared package bythoven_pkg holds:
  - ADDR_W=18 and DATA_W=16.
  - The loader state enum.
  - CYCLES_PER_SEC=50000000.
REQ-036 The STROBE duration counter is the sub-module sram_write_timer (load, count-down, expire pulse); everything else stays in sram_loader.

Verification
REQ-037 Single-word session, WE_LOW_CYCLES=2: START with START_ADDR=18'h00010, then 16'hA5C3 with IN_LAST=1.
  - SRAM_WE is low for exactly 2 cycles at A=18'h00010, D=16'hA5C3.
  - DONE pulses once, 5 cycles after acceptance; WORD_COUNT=1.
REQ-038 Back-to-back session: 4 words 16'h0001..16'h0004 with IN_VALID held high, base address 0.
  - Writes go to addresses 0..3.
  - IN_READY pulses every 5 cycles; WORD_COUNT=4.
REQ-039 Stalled producer: IN_VALID low for 20 cycles between words.
  - The loader stays in WAIT_DATA with SRAM_WE=1 and SRAM_D_OE=0.
  - The session completes correctly afterwards.
REQ-040 Wrap-around: START_ADDR=18'h3FFFF with 2 words.
  - Writes go to 18'h3FFFF, then 18'h00000; WRAPPED=1.
REQ-041 Reset mid-strobe: assert RST during the first STROBE cycle.
  - SRAM_WE=1 and SRAM_D_OE=0 in the same cycle.
  - All outputs are at reset values; a new START works.
REQ-042 START while BUSY, with START_ADDR=18'h00100, mid-session: the address sequence and WORD_COUNT are unchanged.
